// File: rtl/retry_inorder_end.sv
// retry_inorder_end
// Downstream terminator of the retry protocol. Clean results are parked in a
// reorder buffer indexed by their ID. Faulty results are reported back to the
// start stage through a single-entry failed channel. Results leave strictly in
// ID-issue order from the head pointer, so anything younger than a retried ID
// waits until that ID comes back clean.
module retry_inorder_end #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_SIZE    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ID_SIZE-1:0]    id_i,
  input  logic                  faulty_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [ID_SIZE-1:0]    failed_id_o,
  output logic                  failed_valid_o,
  input  logic                  failed_ready_i
);

  localparam int DEPTH = 1 << ID_SIZE;

  // Per-slot state gathered into vectors for indexed access.
  logic [DEPTH-1:0]      w_rob_valid;
  logic [DATA_WIDTH-1:0] w_rob_data [DEPTH];

  logic [ID_SIZE-1:0]    r_head;
  logic                  r_failed_valid;
  logic [ID_SIZE-1:0]    r_failed_id;

  logic w_in_fire;
  logic w_wr_clean;
  logic w_wr_fault;
  logic w_out_fire;
  logic w_fail_fire;

  // An occupied slot back-pressures a reissued ID instead of overwriting it,
  // and nothing is taken while a failed report is still waiting.
  assign ready_o     = !r_failed_valid && !w_rob_valid[id_i];
  assign w_in_fire   = valid_i && ready_o;
  assign w_wr_clean  = w_in_fire && !faulty_i;
  assign w_wr_fault  = w_in_fire && faulty_i;

  // Output is a combinational read of the registered slot at the head.
  assign valid_o     = w_rob_valid[r_head];
  assign data_o      = w_rob_data[r_head];
  assign w_out_fire  = valid_o && ready_i;

  assign failed_valid_o = r_failed_valid;
  assign failed_id_o    = r_failed_id;
  assign w_fail_fire    = r_failed_valid && failed_ready_i;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_slot
      logic                  r_valid;
      logic [DATA_WIDTH-1:0] r_data;
      logic                  w_hit_wr;
      logic                  w_hit_rd;

      assign w_hit_wr = w_wr_clean && (id_i == ID_SIZE'(gi));
      assign w_hit_rd = w_out_fire && (r_head == ID_SIZE'(gi));

      // Slot fill on a clean result, drain on release; a write can never hit
      // the slot being released because that slot is still marked valid.
      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (w_hit_wr) begin
          r_valid <= 1'b1;
          r_data  <= data_i;
        end else if (w_hit_rd) begin
          r_valid <= 1'b0;
        end
      end

      assign w_rob_valid[gi] = r_valid;
      assign w_rob_data[gi]  = r_data;
    end
  endgenerate

  // Head pointer advances by one per release and wraps naturally.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_head <= '0;
    end else if (w_out_fire) begin
      r_head <= r_head + 1'b1;
    end
  end

  // Single-entry failed report, held stable until the start stage takes it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_failed_valid <= 1'b0;
      r_failed_id    <= '0;
    end else if (w_wr_fault) begin
      r_failed_valid <= 1'b1;
      r_failed_id    <= id_i;
    end else if (w_fail_fire) begin
      r_failed_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_retry_inorder_end.sv
// tb_retry_inorder_end
// Directed scenarios followed by a long randomized run. The bench plays the
// start and middle stages: it issues IDs in order, injects faults, reissues
// reported IDs, and checks the released stream against the issue order.
module tb_retry_inorder_end;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic [1:0] id_i;
  logic       faulty_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [1:0] failed_id_o;
  logic       failed_valid_o;
  logic       failed_ready_i;

  retry_inorder_end #(.DATA_WIDTH(8), .ID_SIZE(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_i         (data_i),
    .id_i           (id_i),
    .faulty_i       (faulty_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .failed_id_o    (failed_id_o),
    .failed_valid_o (failed_valid_o),
    .failed_ready_i (failed_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Values sampled just before the active edge of the last step.
  logic       s_ready, s_valid_o, s_fv;
  logic [7:0] s_data_o;
  logic [1:0] s_fid;
  logic       acc_in, acc_out, acc_fail;

  logic [7:0] out_q[$];
  int         out_cyc[$];
  logic [1:0] fail_q[$];
  logic [7:0] exp_q[$];

  // Random-run state
  logic [7:0] gold[$];
  int         send_q[$];
  int         fault_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; samples 1ns before the
  // posedge, records handshakes, and returns at the following negedge.
  task automatic step();
    #4;
    s_ready   = ready_o;
    s_valid_o = valid_o;
    s_data_o  = data_o;
    s_fv      = failed_valid_o;
    s_fid     = failed_id_o;
    acc_in    = valid_i && ready_o;
    acc_out   = valid_o && ready_i;
    acc_fail  = failed_valid_o && failed_ready_i;
    if (acc_out) begin
      out_q.push_back(data_o);
      out_cyc.push_back(cyc);
    end
    if (acc_fail) fail_q.push_back(failed_id_o);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    valid_i = 1'b0; faulty_i = 1'b0; id_i = '0; data_i = '0;
    ready_i = 1'b0; failed_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    out_q.delete(); out_cyc.delete(); fail_q.delete();
  endtask

  task automatic send(input logic [1:0] id, input logic [7:0] d, input logic f, input string tag);
    int n = 0;
    id_i = id; data_i = d; faulty_i = f; valid_i = 1'b1;
    do begin
      step();
      n++;
    end while (!acc_in && n < 50);
    chk({tag, "_accepted"}, 32'(acc_in), 32'd1);
    valid_i = 1'b0; faulty_i = 1'b0;
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < out_q.size()) chk({tag, "_data"}, 32'(out_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int n_items, next_seq, rel, guard, fault_cd, seq;
    logic [7:0] d;

    rst_n = 1'b1;
    valid_i = 1'b0; faulty_i = 1'b0; id_i = '0; data_i = '0;
    ready_i = 1'b0; failed_ready_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_failed_valid", 32'(failed_valid_o), 32'd0);
    chk("rst_failed_id", 32'(failed_id_o), 32'd0);
    rst_n = 1'b0;

    // In-order stream with one-cycle latency and head wrap
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      id_i = 2'(i); data_i = 8'hA0 + 8'(i); valid_i = 1'b1;
      step();
      chk("t1_accept", 32'(acc_in), 32'd1);
      chk("t1_latency_valid", 32'(s_valid_o), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("t1_latency_data", 32'(s_data_o), 32'(8'hA0 + 8'(i - 1)));
    end
    valid_i = 1'b0;
    step();
    chk("t1_last_data", 32'(s_data_o), 32'hA3);
    send(2'd0, 8'hB0, 1'b0, "t1_wrap");
    step();
    chk("t1_wrap_valid", 32'(s_valid_o), 32'd1);
    chk("t1_wrap_data", 32'(s_data_o), 32'hB0);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
    check_out("t1_order");

    // Fault on ID1, report held for 5 cycles, younger IDs held until retry
    do_reset();
    ready_i = 1'b1;
    send(2'd0, 8'h11, 1'b0, "t2_id0");
    send(2'd1, 8'h22, 1'b1, "t2_id1f");
    id_i = 2'd2; data_i = 8'h33; valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_fv_held", 32'(s_fv), 32'd1);
      chk("t3_fid_held", 32'(s_fid), 32'd1);
      chk("t3_ready_low", 32'(s_ready), 32'd0);
      chk("t3_no_output", 32'(s_valid_o), 32'd0);
    end
    failed_ready_i = 1'b1;
    step();
    chk("t3_fail_taken", 32'(acc_fail), 32'd1);
    chk("t3_no_input_same_cycle", 32'(acc_in), 32'd0);
    failed_ready_i = 1'b0;
    send(2'd2, 8'h33, 1'b0, "t2_id2");
    send(2'd3, 8'h44, 1'b0, "t2_id3");
    chk("t2_held_while_missing", out_q.size(), 32'd1);
    send(2'd1, 8'h22, 1'b0, "t2_retry");
    repeat (5) step();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_out("t2_order");
    if (out_cyc.size() == 4) begin
      chk("t2_consec_a", out_cyc[2] - out_cyc[1], 32'd1);
      chk("t2_consec_b", out_cyc[3] - out_cyc[2], 32'd1);
    end
    chk("t2_fail_count", fail_q.size(), 32'd1);

    // Collision on a full buffer
    do_reset();
    for (int i = 0; i < 4; i++) send(2'(i), 8'h10 + 8'(i), 1'b0, "t4_fill");
    id_i = 2'd0; data_i = 8'hC0; valid_i = 1'b1;
    step();
    chk("t4_collision_ready", 32'(s_ready), 32'd0);
    chk("t4_head_valid", 32'(s_valid_o), 32'd1);
    chk("t4_head_data", 32'(s_data_o), 32'h10);
    ready_i = 1'b1;
    step();
    chk("t4_release", 32'(acc_out), 32'd1);
    chk("t4_blocked_same_cycle", 32'(acc_in), 32'd0);
    step();
    chk("t4_new_id0_accepted", 32'(acc_in), 32'd1);
    valid_i = 1'b0;
    repeat (6) step();
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hC0};
    check_out("t4_order");

    // Repeated faults on ID2
    do_reset();
    ready_i = 1'b1; failed_ready_i = 1'b1;
    send(2'd0, 8'h50, 1'b0, "t5_id0");
    send(2'd1, 8'h51, 1'b0, "t5_id1");
    for (int k = 0; k < 3; k++) send(2'd2, 8'h52, 1'b1, "t5_fault");
    send(2'd3, 8'h53, 1'b0, "t5_id3");
    send(2'd2, 8'h52, 1'b0, "t5_retry");
    repeat (6) step();
    chk("t5_fail_count", fail_q.size(), 32'd3);
    foreach (fail_q[i]) chk("t5_fail_id", 32'(fail_q[i]), 32'd2);
    exp_q = '{8'h50, 8'h51, 8'h52, 8'h53};
    check_out("t5_order");

    // Asynchronous reset with entries buffered and a report pending
    do_reset();
    for (int i = 0; i < 3; i++) send(2'(i), 8'h60 + 8'(i), 1'b0, "t6_fill");
    send(2'd3, 8'h63, 1'b1, "t6_fault");
    step();
    chk("t6_pre_fv", 32'(s_fv), 32'd1);
    chk("t6_pre_valid", 32'(s_valid_o), 32'd1);
    rst_n = 1'b1;
    #1;
    chk("t6_async_valid", 32'(valid_o), 32'd0);
    chk("t6_async_fv", 32'(failed_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    out_q.delete(); out_cyc.delete();
    ready_i = 1'b1; id_i = 2'd0;
    step();
    chk("t6_empty_valid", 32'(s_valid_o), 32'd0);
    chk("t6_empty_ready", 32'(s_ready), 32'd1);
    send(2'd0, 8'h77, 1'b0, "t6_id0");
    step();
    chk("t6_head0_valid", 32'(s_valid_o), 32'd1);
    chk("t6_head0_data", 32'(s_data_o), 32'h77);

    // Randomized run against the issue-order golden queue
    do_reset();
    n_items = 10000; next_seq = 0; rel = 0; guard = 0;
    gold.delete(); send_q.delete(); fault_q.delete();
    fault_cd = int'($urandom_range(20, 15));
    while (rel < n_items && guard < 80000) begin
      while (next_seq < n_items && next_seq < rel + 4) begin
        gold.push_back(8'($urandom));
        send_q.push_back(next_seq);
        next_seq++;
      end
      valid_i = (send_q.size() > 0) && ($urandom_range(3, 0) != 0);
      if (send_q.size() > 0) begin
        id_i   = 2'(send_q[0]);
        data_i = gold[send_q[0]];
      end
      faulty_i       = (fault_cd == 0);
      ready_i        = ($urandom_range(3, 0) != 0);
      failed_ready_i = ($urandom_range(2, 0) != 0);
      step();
      guard++;
      if (fault_cd > 0) fault_cd--;
      if (acc_in) begin
        seq = send_q.pop_front();
        if (faulty_i) begin
          fault_q.push_back(seq);
          fault_cd = int'($urandom_range(20, 15));
        end
      end
      if (acc_fail) begin
        chk("rand_fault_pending", fault_q.size(), 32'd1);
        if (fault_q.size() > 0) begin
          seq = fault_q.pop_front();
          chk("rand_fail_id", 32'(s_fid), 32'(seq % 4));
          send_q.push_back(seq);
        end
      end
      while (out_q.size() > 0) begin
        d = out_q.pop_front();
        chk("rand_data", 32'(d), (rel < gold.size()) ? 32'(gold[rel]) : 32'hFFFF_FFFF);
        rel++;
      end
    end
    valid_i = 1'b0; faulty_i = 1'b0;
    chk("rand_all_released", rel, n_items);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/retry_inorder_end.md
Name: retry_inorder_end

Overview:
- Downstream terminator of the retry protocol. It is the in-order counterpart to the plain retry end stage.
- Accepts ID-tagged results from the redundant middle stage and writes each fault-free result into a reorder buffer indexed by ID.
- Reports each faulty ID back to the retry start stage over the failed channel.
- Releases results downstream strictly in ID-issue order. Results that follow a retried item are held until the retried result returns clean.

Parameters:
- DATA_WIDTH, 8, width of the payload.
- ID_SIZE, 2, ID width. Reorder buffer depth is 2**ID_SIZE. Must match the start stage.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- data_i  in  DATA_WIDTH  result payload from the middle stage.
- id_i  in  ID_SIZE  ID attached by the start stage.
- faulty_i  in  1  result mismatch flag, sampled with the handshake.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_o  out  DATA_WIDTH  in-order result.
- valid_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.
- failed_id_o  out  ID_SIZE  ID to be retried.
- failed_valid_o  out  1  failed-report valid.
- failed_ready_i  in  1  start stage accepts the failed report.

Behaviour:
- Reset: clk; reset rst_n, asynchronous, active-high. While rst_n=1:
  - all ROB entry valid bits = 0;
  - head pointer = 0;
  - failed_valid_o = 0, failed_id_o = 0;
  - valid_o = 0, data_o = 0.
  - Reset mid-operation discards all buffered results and any pending failed report. The start stage is reset together with this block.
- Storage: ROB of 2**ID_SIZE entries {valid, data}, addressed by ID. head = next ID to release, width ID_SIZE, wraps modulo 2**ID_SIZE.
- ready_o = !failed_valid_o && !rob[id_i].valid.
  - This is combinational on id_i. A slot collision (ID reissued before release) back-pressures instead of overwriting.
- Input handshake (valid_i && ready_o) with faulty_i=0: rob[id_i] <= {1, data_i} at the next clk edge.
- Input handshake with faulty_i=1:
  - failed_id_o <= id_i and failed_valid_o <= 1 at the next edge;
  - data is dropped and the ROB is not written.
- Failed channel:
  - failed_valid_o and failed_id_o are held stable until failed_ready_i=1.
  - On the edge with failed_valid_o && failed_ready_i, failed_valid_o <= 0.
  - Single-entry register. Because ready_o=0 while it is occupied, no new result (faulty or clean) is accepted that cycle.
- Output:
  - valid_o = rob[head].valid; data_o = rob[head].data (registered storage, combinational read).
  - On valid_o && ready_i: rob[head].valid <= 0 and head <= head+1 (wrap from 2**ID_SIZE-1 to 0).
  - valid_o stays high and data_o stays stable until accepted.
- Latency: a clean result whose ID equals head appears on valid_o one cycle after its input handshake. There is no combinational path from valid_i to valid_o.
- Ordering: if ID k is reported faulty, IDs k+1.. are stored but not released. When the retried k arrives clean, it is released first and the younger IDs follow back-to-back, one per cycle, while ready_i=1.
- Simultaneous events:
  - Release of head and a write to a different slot in the same cycle are both performed.
  - A write to the slot being released in the same cycle is blocked, since ready_o=0 for that ID.
  - An input handshake and a failed-report acceptance in the same cycle cannot occur, because ready_o=0 while failed_valid_o=1.
- Full: all 2**ID_SIZE entries valid. Every ID then collides, ready_o=0, and the block drains through the output only.
- Empty: valid_o=0; data_o holds its last value (don't-care).
- Faulty results repeated for the same ID are reported each time, with no limit on retries.

Test Plan:
- Reset, then inputs IDs 0,1,2,3 with data 8'hA0..8'hA3, all clean, ready_i=1 -> valid_o one cycle after each input; data_o = A0,A1,A2,A3 in order; head wraps to 0. Then ID 0 with data 8'hB0 is released next.
- ID0=11 clean, ID1=22 faulty, ID2=33 clean, ID3=44 clean -> 11 released; failed_id_o=1 with failed_valid_o=1; 33 and 44 held. Retried ID1=22 clean -> outputs 22, 33, 44 on consecutive cycles.
- failed_ready_i=0 for 5 cycles after a fault -> failed_valid_o and failed_id_o stable, ready_o=0 throughout. Upstream data is held, not lost.
- ready_i=0 with IDs 0..3 stored clean -> ready_o=0 for the next ID 0 (collision). Raising ready_i releases ID0, and the new ID 0 is then accepted.
- Same ID 2 faulty three times in a row, then clean -> three failed reports with ID 2; the output order is unchanged.
- Assert rst_n=1 with 3 entries buffered and a failed report pending -> valid_o=0 and failed_valid_o=0 immediately (asynchronous). After release, head=0 and the ROB is empty.
- Random bench, 10000 items with a random fault every 15-20 cycles and random ready/valid delays -> zero mismatches against the golden queue; output is strictly in order.
